cache_fill_fsm: RTL and testbench
=================================

CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 Parameter WORDS_PER_BLOCK, 8, number of 16-bit words fetched per cache block (16-byte block).
REQ-002 Parameter MEM_LATENCY, 4, cycles from a read request to its data_valid return from the multi-cycle memory.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 miss_detected  input  1  cache lookup missed this cycle.
REQ-006 miss_address  input  16  byte address of the missing access.
REQ-007 memory_data_valid  input  1  memory read data valid this cycle.
REQ-008 memory_data  input  16  memory read data.
REQ-009 fsm_busy  output  1  fill in progress; pipeline stalls while high.
REQ-010 mem_enable  output  1  memory read request strobe.
REQ-011 mem_wr  output  1  memory write strobe; held 0 by this block.
REQ-012 memory_address  output  16  word-aligned byte address of the current request.
REQ-013 write_data_array  output  1  write one data word into the cache data array this cycle.
REQ-014 data_word_index  output  3  word slot within the block for write_data_array.
REQ-015 data_array_in  output  16  data to write; equals memory_data.
REQ-016 write_tag_array  output  1  one-cycle pulse writing tag/valid of the filled block.
REQ-017 fill_tag_address  output  16  block base address (miss_address with bits [3:0] cleared), valid while fsm_busy.

Function
REQ-018 States SHALL be IDLE and FILL only.
REQ-019 IDLE->FILL on posedge when miss_detected=1; block base = {miss_address[15:4],4'h0} captured that edge.
REQ-020 In FILL, issue counter (0..8) SHALL drive mem_enable=1 and memory_address=base+2*issue_cnt for issue_cnt<8, incrementing each cycle; mem_enable=0 once issue_cnt=8.
REQ-021 First request SHALL issue in the first FILL cycle; requests SHALL be back-to-back, 8 consecutive cycles, no gaps.
REQ-022 Receive counter (0..7) SHALL increment on each memory_data_valid in FILL; write_data_array=memory_data_valid&(state==FILL), data_word_index=recv_cnt (combinational, same cycle).
REQ-023 When memory_data_valid=1 and recv_cnt=7: write_tag_array=1 that cycle, next state IDLE, counters cleared.
REQ-024 With MEM_LATENCY=4, total fill = 12 FILL cycles; fsm_busy=1 exactly those 12 cycles.
REQ-025 fsm_busy = (state==FILL), combinational.
REQ-026 miss_detected while in FILL SHALL be ignored; base SHALL not change mid-fill.
REQ-027 memory_data_valid in IDLE SHALL be ignored (no writes, no counter change).
REQ-028 Address generation SHALL stay within the block: base 0xFFF0 yields 0xFFF0..0xFFFE, no carry out of bit 3.
REQ-029 In IDLE: mem_enable=0, memory_address=0, write_data_array=0, write_tag_array=0.

Reset
REQ-030 rst=1 SHALL immediately (asynchronously) force state IDLE, both counters 0, base 0; all outputs then take IDLE values, mem_wr=0.
REQ-031 rst mid-fill SHALL abort the fill with no write_tag_array pulse; returns still in flight after release are ignored by REQ-027.
REQ-032 First miss after reset release SHALL start a fresh fill per REQ-019.

Structure
REQ-033 Shared package cache_pkg SHALL hold the state enum (IDLE, FILL), WORDS_PER_BLOCK, MEM_LATENCY, BLOCK_OFFSET_BITS=4.
REQ-034 One sub-module, cache_word_counter (3-bit counter with clear/enable/terminal-count flag), SHALL be instantiated twice (issue, receive).

Verification
REQ-035 Miss at 0x1236 against 4-cycle memory -> requests 0x1230..0x123E on cycles 1-8, write_data_array on cycles 5-12 with index 0..7, write_tag_array on cycle 12, fsm_busy low cycle 13.
REQ-036 Miss at 0xFFFA -> addresses 0xFFF0..0xFFFE, fill_tag_address=0xFFF0, no wrap to 0x0000.
REQ-037 miss_detected held high with changing miss_address during fill -> single fill of original block; next fill starts one cycle after write_tag_array.
REQ-038 rst asserted at fill cycle 6 -> outputs zero immediately, no write_tag_array; later miss at 0x0040 completes normally.
REQ-039 memory_data_valid pulsed while IDLE -> no write_data_array, counters unchanged.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and constants for the cache block-fill controller.
// Holds the fill FSM state enum, block geometry, the memory latency the
// fill schedule assumes, and address helpers used by the FSM.
package cache_pkg;

  localparam int unsigned WORDS_PER_BLOCK   = 8;
  localparam int unsigned MEM_LATENCY       = 4;
  localparam int unsigned BLOCK_OFFSET_BITS = 4;
  localparam int unsigned ADDR_W            = 16;
  localparam int unsigned DATA_W            = 16;
  localparam int unsigned IDX_W             = 3;
  localparam int unsigned TAG_W             = ADDR_W - BLOCK_OFFSET_BITS;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  // Byte address of word idx inside the block whose upper bits are tag.
  // The word index is spliced in, so the address can never carry out of the block.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [IDX_W-1:0] idx);
    return {tag, idx, 1'b0};
  endfunction

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Bundle of the fill controller's miss, memory and cache-array signals.
//   master : the fill FSM (consumes miss/memory returns, drives requests and array writes)
//   slave  : the surrounding cache/memory environment
interface cache_fill_fsm_if;
  import cache_pkg::*;

  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              memory_data_valid;
  logic [DATA_W-1:0] memory_data;
  logic              fsm_busy;
  logic              mem_enable;
  logic              mem_wr;
  logic [ADDR_W-1:0] memory_address;
  logic              write_data_array;
  logic [IDX_W-1:0]  data_word_index;
  logic [DATA_W-1:0] data_array_in;
  logic              write_tag_array;
  logic [ADDR_W-1:0] fill_tag_address;

  modport master (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, mem_enable, mem_wr, memory_address, write_data_array,
           data_word_index, data_array_in, write_tag_array, fill_tag_address
  );

  modport slave (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, mem_enable, mem_wr, memory_address, write_data_array,
           data_word_index, data_array_in, write_tag_array, fill_tag_address
  );

endinterface

// File: rtl/cache_word_counter.sv
// Word-slot counter used for both request issue and data receive.
// Ports: clk, rst (async active-high), clr (sync clear, wins over en),
//        en (advance by one, wraps), count, tc_c (count at LAST, combinational).
module cache_word_counter
  import cache_pkg::*;
#(
  parameter logic [IDX_W-1:0] LAST = IDX_W'(WORDS_PER_BLOCK - 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [IDX_W-1:0] count,
  output logic             tc_c
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + IDX_W'(1);
    end
  end

  assign tc_c = (count == LAST);

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache block-fill controller: on a miss, fetches the 8 words of the
// 16-byte block back-to-back from a pipelined memory, writes each returned
// word into the data array, and pulses the tag write when the last word lands.
// Ports: clk, rst (async active-high), bus (cache_fill_fsm_if.master):
//   miss_detected/miss_address in, memory_data_valid/memory_data in,
//   fsm_busy, mem_enable, mem_wr, memory_address, write_data_array,
//   data_word_index, data_array_in, write_tag_array, fill_tag_address out.
module cache_fill_fsm #(
  parameter int unsigned WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  cache_fill_fsm_if.master bus
);
  import cache_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

  fill_state_e      state_q, state_d;
  logic [TAG_W-1:0] tag_q;
  logic             issue_done_q;
  logic [IDX_W-1:0] issue_cnt, recv_cnt;
  logic             issue_tc_c, recv_tc_c;
  logic             in_fill_c, issue_en_c, recv_en_c, fill_done_c, cnt_clr_c;
  logic             unused_offset_c;

  // Byte offset of the miss is irrelevant: the whole block is fetched.
  assign unused_offset_c = ^bus.miss_address[BLOCK_OFFSET_BITS-1:0];

  assign in_fill_c   = (state_q == FILL);
  assign issue_en_c  = in_fill_c & ~issue_done_q;
  assign recv_en_c   = in_fill_c & bus.memory_data_valid;
  assign fill_done_c = recv_en_c & recv_tc_c;
  // Counters idle at zero outside a fill, so stray returns in IDLE change nothing.
  assign cnt_clr_c   = ~in_fill_c | fill_done_c;

  cache_word_counter #(.LAST(LAST_IDX)) u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr_c),
    .en    (issue_en_c),
    .count (issue_cnt),
    .tc_c  (issue_tc_c)
  );

  cache_word_counter #(.LAST(LAST_IDX)) u_recv_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr_c),
    .en    (recv_en_c),
    .count (recv_cnt),
    .tc_c  (recv_tc_c)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Block tag is captured only on the IDLE->FILL edge; misses during a fill are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q <= '0;
    end else if ((state_q == IDLE) && bus.miss_detected) begin
      tag_q <= bus.miss_address[ADDR_W-1:BLOCK_OFFSET_BITS];
    end
  end

  // Issue count "8": set once the last word request has gone out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_done_q <= 1'b0;
    end else if (cnt_clr_c) begin
      issue_done_q <= 1'b0;
    end else if (issue_en_c && issue_tc_c) begin
      issue_done_q <= 1'b1;
    end
  end

  // Next state and request/write strobes.
  always_comb begin
    state_d              = state_q;
    bus.mem_enable       = 1'b0;
    bus.memory_address   = '0;
    bus.write_data_array = 1'b0;
    bus.write_tag_array  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.miss_detected) begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (!issue_done_q) begin
          bus.mem_enable     = 1'b1;
          bus.memory_address = word_addr(tag_q, issue_cnt);
        end
        if (bus.memory_data_valid) begin
          bus.write_data_array = 1'b1;
          if (recv_tc_c) begin
            bus.write_tag_array = 1'b1;
            state_d             = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.fsm_busy         = in_fill_c;
  assign bus.mem_wr           = 1'b0;
  assign bus.data_word_index  = recv_cnt;
  assign bus.data_array_in    = bus.memory_data;
  assign bus.fill_tag_address = {tag_q, BLOCK_OFFSET_BITS'(0)};

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a fixed-latency pipelined memory model.
module tb_cache_fill_fsm;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic inject = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  cache_fill_fsm_if bus();

  cache_fill_fsm #(.WORDS_PER_BLOCK(WORDS_PER_BLOCK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Memory model: a request seen in cycle k returns in cycle k+MEM_LATENCY
  // with data = address ^ 16'hA5A5. inject forces an unsolicited return.
  logic        hist_en   [MEM_LATENCY];
  logic [15:0] hist_addr [MEM_LATENCY];
  logic        mem_valid = 1'b0;
  logic [15:0] mem_data  = 16'h0;

  assign bus.memory_data_valid = mem_valid | inject;
  assign bus.memory_data       = inject ? 16'hBEEF : mem_data;

  initial begin
    for (int i = 0; i < MEM_LATENCY; i++) begin
      hist_en[i]   = 1'b0;
      hist_addr[i] = 16'h0;
    end
  end

  always @(posedge clk) begin
    for (int i = MEM_LATENCY - 1; i > 0; i--) begin
      hist_en[i]   = hist_en[i-1];
      hist_addr[i] = hist_addr[i-1];
    end
    hist_en[0]   = bus.mem_enable;
    hist_addr[0] = bus.memory_address;
    #1;
    mem_valid = hist_en[MEM_LATENCY-1];
    mem_data  = hist_addr[MEM_LATENCY-1] ^ 16'hA5A5;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Outputs expected in fill cycle c (1 = first FILL cycle, 13 = back in IDLE).
  task automatic check_cycle(input logic [15:0] base, input int c);
    bit busy, men, wr;
    busy = (c <= 12);
    men  = (c <= 8);
    wr   = (c >= 5) && (c <= 12);
    check($sformatf("busy@%0d", c),    16'(bus.fsm_busy), 16'(busy));
    check($sformatf("men@%0d", c),     16'(bus.mem_enable), 16'(men));
    check($sformatf("maddr@%0d", c),   bus.memory_address, men ? base + 16'(2 * (c - 1)) : 16'h0);
    check($sformatf("wr@%0d", c),      16'(bus.write_data_array), 16'(wr));
    check($sformatf("idx@%0d", c),     16'(bus.data_word_index), wr ? 16'(c - 5) : 16'h0);
    check($sformatf("tag@%0d", c),     16'(bus.write_tag_array), 16'(c == 12));
    check($sformatf("mem_wr@%0d", c),  16'(bus.mem_wr), 16'h0);
    if (wr)
      check($sformatf("wdata@%0d", c), bus.data_array_in, (base + 16'(2 * (c - 5))) ^ 16'hA5A5);
    if (busy)
      check($sformatf("ftag@%0d", c),  bus.fill_tag_address, base);
  endtask

  // Caller raises miss at a negedge; this follows cycles 1..13 of the fill.
  task automatic watch_fill(input logic [15:0] base, input bit hold);
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (hold) bus.miss_address = bus.miss_address + 16'h0110;
      else      bus.miss_detected = 1'b0;
      check_cycle(base, c);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 16'(bus.fsm_busy), 16'h0);
    check({tag, "_men"},  16'(bus.mem_enable), 16'h0);
    check({tag, "_addr"}, bus.memory_address, 16'h0);
    check({tag, "_wr"},   16'(bus.write_data_array), 16'h0);
    check({tag, "_tag"},  16'(bus.write_tag_array), 16'h0);
    check({tag, "_idx"},  16'(bus.data_word_index), 16'h0);
  endtask

  initial begin
    logic [15:0] nb;
    rst = 1'b1;
    bus.miss_detected = 1'b0;
    bus.miss_address  = 16'h0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_ftag",   bus.fill_tag_address, 16'h0);
    check("reset_mem_wr", 16'(bus.mem_wr), 16'h0);
    rst = 1'b0;
    @(negedge clk);

    // Basic fill from a mid-block address.
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'h1236;
    watch_fill(16'h1230, 1'b0);

    // Top-of-memory block must not wrap.
    @(negedge clk);
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'hFFFA;
    watch_fill(16'hFFF0, 1'b0);

    // Miss held high with moving address: one fill, then the next one after a single IDLE cycle.
    @(negedge clk);
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'h2468;
    watch_fill(16'h2460, 1'b1);
    nb = {bus.miss_address[15:4], 4'h0};
    watch_fill(nb, 1'b0);

    // Stray memory returns while IDLE are ignored.
    repeat (2) @(negedge clk);
    inject = 1'b1;
    #1;
    check_idle_outputs("stray0");
    @(negedge clk);
    check_idle_outputs("stray1");
    inject = 1'b0;
    @(negedge clk);
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'h1236;
    watch_fill(16'h1230, 1'b0);

    // Reset in fill cycle 6 aborts the fill; in-flight returns are dropped.
    @(negedge clk);
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'h5554;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      bus.miss_detected = 1'b0;
      check_cycle(16'h5550, c);
    end
    rst = 1'b1;
    #1;
    check_idle_outputs("abort");
    check("abort_ftag", bus.fill_tag_address, 16'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_idle_outputs($sformatf("post%0d", k));
      if (k == 1) rst = 1'b0;
    end

    // Fresh fill after the aborted one.
    repeat (2) @(negedge clk);
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'h0040;
    watch_fill(16'h0040, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
